// File: rtl/round_ctrl.sv
// round_ctrl: single-round memory-game controller.
// It displays a captured symbol pattern one step per timer expiry, then checks
// the player's keys against the same pattern. Timer expiries while waiting for
// a key are counted, and the round is lost when the count reaches TIMEOUT_TICKS.
//
// Parameters
//   TIMEOUT_TICKS  expirations allowed while waiting for one key (1..15)
// Ports
//   clock       rising-edge clock
//   rst         asynchronous active-high reset
//   start       round request; accepted only in idle/win/lose
//   level       round length code, steps = level + 1
//   pattern     symbol sequence, step i = pattern[2i+1:2i]
//   tmr_start   one-cycle pulse that arms the external timer
//   tmr_done    one-cycle timer expiry pulse
//   key_valid   one-cycle player entry strobe
//   key_sym     player symbol, qualified by key_valid
//   show_valid  a pattern symbol is being displayed
//   show_sym    displayed symbol, 0 when not displaying
//   busy        round in progress (show or input phase)
//   win, lose   round result, held until the next accepted start
module round_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 5
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  level,
  input  logic [15:0] pattern,
  output logic        tmr_start,
  input  logic        tmr_done,
  input  logic        key_valid,
  input  logic [1:0]  key_sym,
  output logic        show_valid,
  output logic [1:0]  show_sym,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  localparam logic [3:0] TimeoutLim = 4'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {StIdle, StShow, StInput, StWin, StLose} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  last_q, last_d;   // index of the final step (captured level)
  logic [15:0] pat_q, pat_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic        tmr_start_q, tmr_start_d;
  logic        show_valid_q, show_valid_d;
  logic [1:0]  show_sym_q, show_sym_d;
  logic        busy_q, busy_d;

  logic [1:0]  cur_sym;
  logic [3:0]  tcnt_inc;

  assign cur_sym  = 2'(pat_q >> {idx_q, 1'b0});
  assign tcnt_inc = tcnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    last_d      = last_q;
    pat_d       = pat_q;
    win_d       = win_q;
    lose_d      = lose_q;
    tmr_start_d = 1'b0;

    case (state_q)
      StIdle, StWin, StLose: begin
        if (start) begin
          state_d     = StShow;
          idx_d       = 3'd0;
          tcnt_d      = 4'd0;
          last_d      = level;
          pat_d       = pattern;
          win_d       = 1'b0;
          lose_d      = 1'b0;
          tmr_start_d = 1'b1;
        end
      end
      StShow: begin
        if (tmr_done) begin
          tmr_start_d = 1'b1;
          if (idx_q != last_q) begin
            idx_d = idx_q + 3'd1;
          end else begin
            state_d = StInput;
            idx_d   = 3'd0;
            tcnt_d  = 4'd0;
          end
        end
      end
      StInput: begin
        // A key in the same cycle as an expiry takes priority; the expiry is dropped.
        if (key_valid) begin
          if (key_sym != cur_sym) begin
            state_d = StLose;
            lose_d  = 1'b1;
          end else if (idx_q != last_q) begin
            idx_d       = idx_q + 3'd1;
            tcnt_d      = 4'd0;
            tmr_start_d = 1'b1;
          end else begin
            state_d = StWin;
            win_d   = 1'b1;
          end
        end else if (tmr_done) begin
          if (tcnt_inc == TimeoutLim) begin
            state_d = StLose;
            lose_d  = 1'b1;
          end else begin
            tcnt_d      = tcnt_inc;
            tmr_start_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of what the next state implies.
    busy_d       = (state_d == StShow) || (state_d == StInput);
    show_valid_d = (state_d == StShow);
    show_sym_d   = show_valid_d ? 2'(pat_d >> {idx_d, 1'b0}) : 2'd0;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      tcnt_q       <= 4'd0;
      last_q       <= 3'd0;
      pat_q        <= 16'd0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      tmr_start_q  <= 1'b0;
      show_valid_q <= 1'b0;
      show_sym_q   <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tcnt_q       <= tcnt_d;
      last_q       <= last_d;
      pat_q        <= pat_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      tmr_start_q  <= tmr_start_d;
      show_valid_q <= show_valid_d;
      show_sym_q   <= show_sym_d;
      busy_q       <= busy_d;
    end
  end

  assign tmr_start  = tmr_start_q;
  assign show_valid = show_valid_q;
  assign show_sym   = show_sym_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: directed scenarios plus randomized rounds
// checked against a round-level model (expected symbols, outcome, timer pulses).
module tb_round_ctrl;
  localparam int unsigned TO = 5;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  level = 3'd0;
  logic [15:0] pattern = 16'd0;
  logic        tmr_done = 1'b0;
  logic        key_valid = 1'b0;
  logic [1:0]  key_sym = 2'd0;
  logic        tmr_start, show_valid, busy, win, lose;
  logic [1:0]  show_sym;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  round_ctrl #(.TIMEOUT_TICKS(TO)) dut (
    .clock(clock), .rst(rst), .start(start), .level(level), .pattern(pattern),
    .tmr_start(tmr_start), .tmr_done(tmr_done), .key_valid(key_valid), .key_sym(key_sym),
    .show_valid(show_valid), .show_sym(show_sym), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  // Running count of timer-arm pulses, sampled mid-cycle.
  always @(negedge clock) if (tmr_start === 1'b1) pulses++;

  function automatic logic [1:0] sym_of(input logic [15:0] p, input int i);
    return 2'((p >> (2 * i)) & 16'h3);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input logic [2:0] lv, input logic [15:0] pt);
    start = 1'b1; level = lv; pattern = pt;
    tick();
    start = 1'b0; level = 3'($urandom); pattern = 16'($urandom);
  endtask

  task automatic pulse_done;
    tmr_done = 1'b1;
    tick();
    tmr_done = 1'b0;
  endtask

  task automatic press(input logic [1:0] k);
    key_valid = 1'b1; key_sym = k;
    tick();
    key_valid = 1'b0; key_sym = 2'($urandom);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++; if ({tmr_start, show_valid, show_sym, busy, win, lose} !== 7'd0) begin
      failures++; $display("FAIL reset_outputs got %b want 0000000",
                           {tmr_start, show_valid, show_sym, busy, win, lose}); end
    start = 1'b1; level = 3'd0; pattern = 16'h0002;
    idle(2);
    checks++; if (show_valid !== 1'b0) begin
      failures++; $display("FAIL reset_holds_idle got %b want 0", show_valid); end
    @(negedge clock) rst = 1'b0;
    tick();
    start = 1'b0;
    checks++; if ({show_valid, show_sym, tmr_start, busy} !== 5'b11011) begin
      failures++; $display("FAIL first_start got %b want 11011",
                           {show_valid, show_sym, tmr_start, busy}); end
    pulse_done();
    press(2'd2);
    checks++; if (win !== 1'b1) begin
      failures++; $display("FAIL first_round_win got %b want 1", win); end
  endtask

  task automatic test_show_win;
    do_start(3'd2, 16'h0024);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({show_valid, show_sym} !== {1'b1, 2'(i)}) begin
        failures++; $display("FAIL show_step%0d got %b want %b", i, {show_valid, show_sym},
                             {1'b1, 2'(i)}); end
      pulse_done();
    end
    checks++; if ({show_valid, show_sym, busy, tmr_start} !== 4'b0011) begin
      failures++; $display("FAIL enter_input got %b want 0011",
                           {show_valid, show_sym, busy, tmr_start}); end
    for (int i = 0; i < 3; i++) press(2'(i));
    checks++; if ({win, lose, busy} !== 3'b100) begin
      failures++; $display("FAIL show_win got %b want 100", {win, lose, busy}); end
  endtask

  task automatic test_lose_key;
    do_start(3'd1, 16'h0007);
    checks++; if (win !== 1'b0) begin
      failures++; $display("FAIL win_cleared got %b want 0", win); end
    pulse_done(); pulse_done();
    press(2'd3);
    checks++; if (lose !== 1'b0) begin
      failures++; $display("FAIL lose_early got %b want 0", lose); end
    press(2'd0);
    checks++; if ({win, lose, busy} !== 3'b010) begin
      failures++; $display("FAIL wrong_key_lose got %b want 010", {win, lose, busy}); end
  endtask

  task automatic test_timeout;
    int base;
    do_start(3'd0, 16'($urandom));
    pulse_done();
    tick();
    base = pulses;
    for (int t = 0; t < int'(TO); t++) begin
      pulse_done();
      checks++; if (lose !== (t == int'(TO) - 1)) begin
        failures++; $display("FAIL timeout_%0d lose got %b want %b", t, lose,
                             (t == int'(TO) - 1)); end
      tick();
    end
    checks++; if (pulses - base !== int'(TO) - 1) begin
      failures++; $display("FAIL timeout_rearms got %0d want %0d", pulses - base, TO - 1); end
  endtask

  task automatic test_simul;
    logic [15:0] pt;
    int base;
    pt = 16'($urandom);
    do_start(3'd1, pt);
    pulse_done(); pulse_done();
    tick();
    pulse_done();
    tick();
    base = pulses;
    key_valid = 1'b1; key_sym = sym_of(pt, 0); tmr_done = 1'b1;
    tick();
    key_valid = 1'b0; tmr_done = 1'b0;
    checks++; if ({tmr_start, busy, lose} !== 3'b110) begin
      failures++; $display("FAIL simul_rearm got %b want 110", {tmr_start, busy, lose}); end
    tick();
    checks++; if (pulses - base !== 1) begin
      failures++; $display("FAIL simul_pulses got %0d want 1", pulses - base); end
    // The timeout count must have restarted from zero.
    for (int t = 0; t < int'(TO) - 1; t++) begin pulse_done(); tick(); end
    checks++; if (lose !== 1'b0) begin
      failures++; $display("FAIL simul_tcnt lose got %b want 0", lose); end
    press(sym_of(pt, 1));
    checks++; if (win !== 1'b1) begin
      failures++; $display("FAIL simul_index win got %b want 1", win); end
  endtask

  task automatic test_async_reset;
    logic [15:0] pt;
    do_start(3'd3, 16'($urandom));
    pulse_done();
    checks++; if ({show_valid, busy} !== 2'b11) begin
      failures++; $display("FAIL mid_show got %b want 11", {show_valid, busy}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({tmr_start, show_valid, show_sym, busy, win, lose} !== 7'd0) begin
      failures++; $display("FAIL async_reset got %b want 0000000",
                           {tmr_start, show_valid, show_sym, busy, win, lose}); end
    @(negedge clock) rst = 1'b0;
    pt = 16'($urandom);
    do_start(3'd3, pt);
    checks++; if ({show_valid, show_sym} !== {1'b1, sym_of(pt, 0)}) begin
      failures++; $display("FAIL replay_step0 got %b want %b", {show_valid, show_sym},
                           {1'b1, sym_of(pt, 0)}); end
    pulse_done();
    checks++; if (show_sym !== sym_of(pt, 1)) begin
      failures++; $display("FAIL replay_step1 got %0d want %0d", show_sym, sym_of(pt, 1)); end
    for (int i = 0; i < 3; i++) pulse_done();
    for (int i = 0; i < 4; i++) press(sym_of(pt, i));
  endtask

  task automatic test_ignore;
    logic [15:0] pt;
    pt = 16'($urandom);
    do_start(3'd0, pt);
    pulse_done();
    do_start(3'd0, ~pt);
    checks++; if ({show_valid, busy, tmr_start} !== 3'b010) begin
      failures++; $display("FAIL start_in_input got %b want 010",
                           {show_valid, busy, tmr_start}); end
    press(sym_of(pt, 0));
    checks++; if (win !== 1'b1) begin
      failures++; $display("FAIL ignore_win got %b want 1", win); end
    pulse_done();
    press(~sym_of(pt, 0));
    idle(2);
    checks++; if ({win, lose, busy, tmr_start, show_valid} !== 5'b10000) begin
      failures++; $display("FAIL win_held got %b want 10000",
                           {win, lose, busy, tmr_start, show_valid}); end
    do_start(3'd0, pt);
    checks++; if ({win, busy} !== 2'b01) begin
      failures++; $display("FAIL win_cleared_restart got %b want 01", {win, busy}); end
    pulse_done();
    press(sym_of(pt, 0));
  endtask

  task automatic test_random;
    int lv, mode, bad, exp_p, base, to_n;
    logic [15:0] pt;
    bit exp_win;
    for (int r = 0; r < 25; r++) begin
      lv = $urandom_range(0, 7); pt = 16'($urandom);
      mode = $urandom_range(0, 2); bad = $urandom_range(0, lv);
      base = pulses; exp_p = 0;
      do_start(3'(lv), pt); exp_p++;
      for (int i = 0; i <= lv; i++) begin
        checks++; if ({show_valid, show_sym} !== {1'b1, sym_of(pt, i)}) begin
          failures++; $display("FAIL rand_show r%0d step%0d got %b want %b", r, i,
                               {show_valid, show_sym}, {1'b1, sym_of(pt, i)}); end
        idle($urandom_range(0, 2));
        pulse_done(); exp_p++;
      end
      exp_win = 1'b1;
      for (int i = 0; i <= lv; i++) begin
        to_n = (mode == 2 && i == bad) ? int'(TO) : $urandom_range(0, TO - 1);
        for (int t = 0; t < to_n; t++) begin
          idle($urandom_range(0, 1));
          pulse_done();
          if (t < int'(TO) - 1) exp_p++;
        end
        if (mode == 2 && i == bad) begin exp_win = 1'b0; break; end
        if (mode == 1 && i == bad) begin
          press(sym_of(pt, i) + 2'd1); exp_win = 1'b0; break;
        end
        idle($urandom_range(0, 1));
        press(sym_of(pt, i));
        if (i < lv) exp_p++;
      end
      tick();
      checks++; if ({win, lose, busy} !== {exp_win, !exp_win, 1'b0}) begin
        failures++; $display("FAIL rand_result r%0d got %b want %b", r, {win, lose, busy},
                             {exp_win, !exp_win, 1'b0}); end
      checks++; if (pulses - base !== exp_p) begin
        failures++; $display("FAIL rand_pulses r%0d got %0d want %0d", r, pulses - base,
                             exp_p); end
    end
  endtask

  initial begin
    test_reset();
    test_show_win();
    test_lose_key();
    test_timeout();
    test_simul();
    test_async_reset();
    test_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
